// File: rtl/uart_tx_fsm.sv
// UART transmit framing FSM: emits start, serializer-driven payload, optional parity and stop bit.
// Payload bit counting lives in the external serializer; this block only follows its ser_flag.
module uart_tx_fsm #(
  parameter int unsigned data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  data_valid,
  input  logic [data_width-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  input  logic                  ser_flag,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state;
  logic   par_bit;
  logic   par_en_q;

  // Frame attributes are captured only on acceptance so an in-flight frame is immutable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            par_en_q <= par_en;
            par_bit  <= par_typ ? ~^p_data : ^p_data;
            state    <= START;
          end
        end
        START:   state <= DATA;
        DATA: begin
          if (!ser_flag) state <= par_en_q ? PARITY : STOP;
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line and serializer controls decode from state only; reset lands here via the state register.
  always_comb begin
    TX_OUT   = 1'b1;
    busy     = 1'b0;
    ser_load = 1'b1;
    ser_en   = 1'b0;
    case (state)
      START: begin
        TX_OUT   = 1'b0;
        busy     = 1'b1;
        ser_load = 1'b0;
        ser_en   = 1'b1;
      end
      DATA: begin
        TX_OUT   = ser_data;
        busy     = 1'b1;
        ser_load = 1'b0;
        ser_en   = ser_flag;
      end
      PARITY: begin
        TX_OUT   = par_bit;
        busy     = 1'b1;
        ser_load = 1'b0;
      end
      STOP: begin
        busy     = 1'b1;
        ser_load = 1'b0;
      end
      default: begin
        TX_OUT   = 1'b1;
        busy     = 1'b0;
        ser_load = 1'b1;
        ser_en   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm paired with a behavioural serializer; expected line/busy per cycle
// are queued when a frame is requested and popped as the DUT produces them.
module tb_uart_tx_fsm;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         data_valid;
  logic [W-1:0] p_data;
  logic         par_en;
  logic         par_typ;
  logic         ser_data;
  logic         ser_flag;
  logic         ser_load;
  logic         ser_en;
  logic         busy;
  logic         TX_OUT;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected {TX_OUT, busy} per cycle
  logic [1:0] q[$];

  uart_tx_fsm #(.data_width(W)) dut (
    .CLK(CLK), .RST(RST), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data), .ser_flag(ser_flag),
    .ser_load(ser_load), .ser_en(ser_en), .busy(busy), .TX_OUT(TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Serializer model: loads while ser_load, presents one bit per enabled cycle, LSB first.
  logic [W-1:0] sh;
  logic [3:0]   cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh       <= '0;
      cnt      <= 4'd0;
      ser_data <= 1'b0;
    end else if (ser_load) begin
      sh  <= p_data;
      cnt <= 4'd0;
    end else if (ser_en) begin
      ser_data <= sh[0];
      sh       <= sh >> 1;
      cnt      <= cnt + 4'd1;
    end
  end
  assign ser_flag = (cnt != 4'(W));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    logic p;
    p = pt ? ~^d : ^d;
    q.push_back(2'b01);
    for (int i = 0; i < int'(W); i++) q.push_back({d[i], 1'b1});
    if (pe) q.push_back({p, 1'b1});
    q.push_back(2'b11);
    q.push_back(2'b10);
  endtask

  task automatic step_check(input string tag);
    logic [1:0] e;
    @(negedge CLK);
    if (q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = q.pop_front();
      check({tag, "_tx"}, TX_OUT, e[1]);
      check({tag, "_busy"}, busy, e[0]);
      check({tag, "_load"}, ser_load, ~e[0]);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step_check(tag);
  endtask

  task automatic request(input logic [W-1:0] d, input logic pe, input logic pt);
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    push_frame(d, pe, pt);
  endtask

  initial begin
    RST        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #12;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_load", ser_load, 1'b1);
    check("rst_en", ser_en, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Long idle
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_tx", TX_OUT, 1'b1);
      check("idle_load", ser_load, 1'b1);
      check("idle_en", ser_en, 1'b0);
      check("idle_busy", busy, 1'b0);
    end

    // 0xA5 without parity
    request(8'hA5, 1'b0, 1'b0);
    step_check("a5_np");
    check("a5_start_en", ser_en, 1'b1);
    data_valid = 1'b0;
    run("a5_np", 10);

    // 0xA5 even parity
    request(8'hA5, 1'b1, 1'b0);
    step_check("a5_even");
    data_valid = 1'b0;
    run("a5_even", 11);

    // 0x00 odd parity
    request(8'h00, 1'b1, 1'b1);
    step_check("z_odd");
    data_valid = 1'b0;
    run("z_odd", 11);

    // data_valid held: two frames with exactly one idle cycle between
    request(8'h3C, 1'b0, 1'b0);
    push_frame(8'h3C, 1'b0, 1'b0);
    run("b2b", 12);
    data_valid = 1'b0;
    run("b2b", 10);

    // Mid-frame request with different payload must be ignored
    request(8'hA5, 1'b0, 1'b0);
    step_check("ignore");
    data_valid = 1'b0;
    run("ignore", 3);
    data_valid = 1'b1;
    p_data     = 8'hFF;
    par_en     = 1'b1;
    par_typ    = 1'b1;
    step_check("ignore");
    data_valid = 1'b0;
    run("ignore", 6);

    // Reset during the 4th DATA cycle
    request(8'h5A, 1'b0, 1'b0);
    step_check("abort");
    data_valid = 1'b0;
    run("abort", 3);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("abort_tx", TX_OUT, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_load", ser_load, 1'b1);
    check("abort_en", ser_en, 1'b0);
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    q.push_back(2'b10);
    step_check("post_rst_idle");

    // 0x81 even parity after reset
    request(8'h81, 1'b1, 1'b0);
    step_check("x81");
    data_valid = 1'b0;
    run("x81", 11);

    n_checks++;
    assert (q.size() == 0) else begin
      n_fails++;
      $error("FAIL sb_drain: observed %0d leftover entries expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter data_width, default 8, giving the number of payload bits per frame.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates occur on its rising edge, one CLK cycle per line bit.
REQ-003 SHALL have port RST  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port data_valid  input  1  a new frame is requested; sampled only in IDLE.
REQ-005 SHALL have port p_data  input  data_width  parallel payload; used for parity, sampled with data_valid.
REQ-006 SHALL have port par_en  input  1  1 = insert a parity bit; sampled with data_valid.
REQ-007 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity; sampled with data_valid.
REQ-008 SHALL have port ser_data  input  1  serial payload bit from the serializer stage, LSB first.
REQ-009 SHALL have port ser_flag  input  1  from the serializer: 1 = payload bits remain to shift, 0 = last bit presented.
REQ-010 SHALL have port ser_load  output  1  load/restart strobe to the serializer (drives its ser_RST).
REQ-011 SHALL have port ser_en  output  1  shift enable to the serializer (drives its serialize_en).
REQ-012 SHALL have port busy  output  1  frame in progress; also fed back to the serializer.
REQ-013 SHALL have port TX_OUT  output  1  UART line output; idle high.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP, held in a state register updated on rising CLK.
REQ-015 IDLE SHALL drive TX_OUT=1, busy=0, ser_load=1 and ser_en=0.
REQ-016 In IDLE with data_valid=1 at a rising edge, the block SHALL latch par_en, par_typ and the parity bit, then move to START.
REQ-017 The parity bit SHALL be ^p_data for even parity (par_typ=0) and ~^p_data for odd parity (par_typ=1).
REQ-018 In IDLE with data_valid=0, the state SHALL remain IDLE.
REQ-019 START SHALL last exactly 1 cycle, with TX_OUT=0, busy=1, ser_load=0 and ser_en=1; it SHALL then move to DATA.
REQ-020 DATA SHALL drive TX_OUT=ser_data, busy=1, ser_load=0 and ser_en=ser_flag.
REQ-021 DATA SHALL be left at the rising edge where ser_flag=0 (the last payload bit): to PARITY if the latched par_en=1, otherwise to STOP.
REQ-022 DATA SHALL last data_width cycles when paired with the team serializer; the block SHALL NOT count bits itself.
REQ-023 PARITY SHALL last 1 cycle with TX_OUT equal to the latched parity bit, busy=1 and ser_en=0; it SHALL then move to STOP.
REQ-024 STOP SHALL last 1 cycle with TX_OUT=1, busy=1 and ser_en=0; it SHALL then always move to IDLE.
REQ-025 Back-to-back frames SHALL always be separated by at least 1 IDLE cycle, during which the serializer reloads.
REQ-026 data_valid, p_data, par_en and par_typ SHALL be ignored in every state other than IDLE; an in-flight frame SHALL never be modified.
REQ-027 TX_OUT, busy, ser_load and ser_en SHALL be decoded only from the state register, the latched parity bit, the latched par_en, ser_data and ser_flag, with no other combinational input paths.
REQ-028 Frame length in cycles SHALL be 1 + data_width + par_en + 1 (10 or 11 for data_width=8).
REQ-029 Unreachable state encodings SHALL return to IDLE on the next rising CLK edge.

Reset
REQ-030 RST=1 SHALL immediately (asynchronously) force the state to IDLE and clear the latched parity and par_en.
REQ-031 During reset the outputs SHALL be TX_OUT=1, busy=0, ser_load=1 and ser_en=0.
REQ-032 RST asserted mid-frame (any state) SHALL abort the frame with no stop bit emitted; the line SHALL return high at once.
REQ-033 After RST deasserts, the first frame SHALL be accepted on the first rising edge where data_valid=1.

Verification (the bench pairs the block with the team serializer, data_width=8)
REQ-034 Frame 0xA5, par_en=0 -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 cycles.
REQ-035 Frame 0xA5, par_en=1, par_typ=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (parity 0); busy high for 11 cycles.
REQ-036 Frame 0x00, par_en=1, par_typ=1 -> parity bit 1; TX_OUT = 0, eight 0s, 1, 1.
REQ-037 data_valid held high continuously with 0x3C, par_en=0 -> frames repeat with exactly 1 idle-high cycle between stop and start. data_valid pulsing mid-frame with different p_data -> no effect on the current frame.
REQ-038 RST pulsed during the 4th DATA cycle -> TX_OUT=1 and busy=0 in the same cycle. A following 0x81 frame is transmitted correctly.
REQ-039 Idle with data_valid=0 for 20 cycles -> TX_OUT=1, ser_load=1 and ser_en=0 throughout.
